// File: rtl/hamming_dec_engine.sv
// Hamming(16,11) SECDED decoder: reads encoded words from DataMem, writes corrected data plus flag.
// Optional statistics counters are enabled with `define HAMDEC_STATS_EN.
module hamming_dec_engine #(
    parameter int NUM_WORDS = 15,
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Ack,
    output logic [7:0] MemAddr,
    input  logic [7:0] MemRdData,
    output logic [7:0] MemWrData,
    output logic       MemWrEn,
    output logic [7:0] CorrCnt,
    output logic [7:0] DblCnt
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD_LO  = 3'd1;
    localparam logic [2:0] RD_HI  = 3'd2;
    localparam logic [2:0] DECODE = 3'd3;
    localparam logic [2:0] WR_LO  = 3'd4;
    localparam logic [2:0] WR_HI  = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    localparam logic [7:0] SRC8    = SRC_BASE[7:0];
    localparam logic [7:0] DST8    = DST_BASE[7:0];
    localparam logic [7:0] LAST_IX = 8'(NUM_WORDS - 1);

    logic [2:0]  state;
    logic [7:0]  idx;
    logic [15:0] cw;
    logic [3:0]  synd;
    logic        par;
    logic [10:0] data;
    logic [1:0]  flag;

    logic [3:0]  sNext;
    logic        pNext;
    logic [15:0] cwFix;
    logic [1:0]  fNext;
    logic [10:0] dNext;
    logic [7:0]  idx2;

    // Syndrome is the XOR of set-bit positions; overall parity separates single from double errors.
    always_comb begin
        sNext = '0;
        for (int k = 1; k < 16; k++)
            if (cw[k]) sNext = sNext ^ 4'(k);
        pNext = ^cw;
        cwFix = cw;
        if (pNext) cwFix[sNext] = ~cw[sNext];
        if (pNext)              fNext = 2'b01;
        else if (sNext != 4'd0) fNext = 2'b10;
        else                    fNext = 2'b00;
        dNext = {cwFix[15:9], cwFix[7:5], cwFix[3]};
    end

    always_comb begin
        if (par)               flag = 2'b01;
        else if (synd != 4'd0) flag = 2'b10;
        else                   flag = 2'b00;
    end

    assign idx2 = {idx[6:0], 1'b0};

    always_comb begin
        MemAddr   = '0;
        MemWrData = '0;
        MemWrEn   = 1'b0;
        case (state)
            RD_LO: MemAddr = SRC8 + idx2;
            RD_HI: MemAddr = SRC8 + idx2 + 8'd1;
            WR_LO: begin
                MemAddr   = DST8 + idx2;
                MemWrData = data[7:0];
                MemWrEn   = 1'b1;
            end
            WR_HI: begin
                MemAddr   = DST8 + idx2 + 8'd1;
                MemWrData = {flag, 3'b000, data[10:8]};
                MemWrEn   = 1'b1;
            end
            default: ;
        endcase
    end

    // Ack is registered from DONE so it trails DONE entry by one cycle; DONE is only left
    // once Ack has been visible, so a requester never misses completion.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
            Ack   <= 1'b0;
            idx   <= '0;
            cw    <= '0;
            synd  <= '0;
            par   <= 1'b0;
            data  <= '0;
        end else begin
            case (state)
                IDLE: if (Start) begin
                    state <= RD_LO;
                    idx   <= '0;
                end
                RD_LO: begin
                    cw[7:0] <= MemRdData;
                    state   <= RD_HI;
                end
                RD_HI: begin
                    cw[15:8] <= MemRdData;
                    state    <= DECODE;
                end
                DECODE: begin
                    synd  <= sNext;
                    par   <= pNext;
                    data  <= dNext;
                    state <= WR_LO;
                end
                WR_LO: state <= WR_HI;
                WR_HI: begin
                    if (idx == LAST_IX) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + 8'd1;
                        state <= RD_LO;
                    end
                end
                DONE: begin
                    Ack <= 1'b1;
                    if (Ack && !Start) begin
                        Ack   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HAMDEC_STATS_EN
    logic [7:0] corrQ;
    logic [7:0] dblQ;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            corrQ <= '0;
            dblQ  <= '0;
        end else if (state == IDLE && Start) begin
            corrQ <= '0;
            dblQ  <= '0;
        end else if (state == DECODE) begin
            if (fNext == 2'b01 && corrQ != 8'hFF) corrQ <= corrQ + 8'd1;
            if (fNext == 2'b10 && dblQ != 8'hFF)  dblQ  <= dblQ + 8'd1;
        end
    end

    assign CorrCnt = corrQ;
    assign DblCnt  = dblQ;
`else
    assign CorrCnt = 8'h00;
    assign DblCnt  = 8'h00;
`endif

endmodule
